// File: rtl/tft43_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tft43_pkg
// Description : Shared trigger codes, sequencer state encoding and colour
//               type for the TFT43 rectangle-fill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tft43_pkg;

    // Command codes understood by the TFT43 command engine
    localparam logic [3:0] TRG_IDLE  = 4'd0;
    localparam logic [3:0] TRG_RST   = 4'd1;
    localparam logic [3:0] TRG_INIT  = 4'd2;
    localparam logic [3:0] TRG_CASET = 4'd3;
    localparam logic [3:0] TRG_RASET = 4'd4;
    localparam logic [3:0] TRG_GRAM  = 4'd5;
    localparam logic [3:0] TRG_DISP  = 4'd6;
    localparam logic [3:0] TRG_DATA  = 4'd7;

    // RGB565 pixel colour
    typedef logic [15:0] rgb565_t;

    // Sequencer states: power-up chain, idle, then the per-fill chain
    typedef enum logic [3:0] {
        S_PWR_WAIT = 4'd0,
        S_RST      = 4'd1,
        S_INIT     = 4'd2,
        S_DISP     = 4'd3,
        S_IDLE     = 4'd4,
        S_CASET    = 4'd5,
        S_RASET    = 4'd6,
        S_GRAM     = 4'd7,
        S_PIX      = 4'd8,
        S_FIN      = 4'd9
    } state_t;

    // A rectangle is legal when ordered and entirely inside the panel
    function automatic logic rect_legal(
        input logic [15:0] x0,
        input logic [15:0] y0,
        input logic [15:0] x1,
        input logic [15:0] y1,
        input logic [15:0] x_lim,
        input logic [15:0] y_lim
    );
        return (x0 <= x1) && (y0 <= y1) && (x1 < x_lim) && (y1 < y_lim);
    endfunction

endpackage : tft43_pkg
`default_nettype wire

// File: rtl/tft43_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tft43_cmd_issuer
// Description : Owns the lcd_en / lcd_done handshake to the TFT43 command
//               engine. A command is latched when the port is idle, held
//               stable until lcd_done, then lcd_en drops for one cycle so the
//               engine re-arms before the next command is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tft43_cmd_issuer
    import tft43_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    // sequencer side
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_trigger,
    input  logic [15:0] cmd_d1,
    input  logic [15:0] cmd_d2,
    output logic        cmd_ack,
    // engine side
    output logic        lcd_en,
    output logic [3:0]  lcd_trigger,
    output logic [15:0] lcd_data1,
    output logic [15:0] lcd_data2,
    input  logic        lcd_done
);

    logic        en_q,   en_d;
    logic [3:0]  trg_q,  trg_d;
    logic [15:0] d1_q,   d1_d;
    logic [15:0] d2_q,   d2_d;

    // Next-state: load only while lcd_en is low, so operands never move
    // during an active command. The cycle after done is always a low cycle
    // because en_q is high on the done edge and cannot reload there.
    always_comb begin
        en_d    = en_q;
        trg_d   = trg_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        cmd_ack = 1'b0;
        if (en_q) begin
            if (lcd_done) begin
                en_d    = 1'b0;
                cmd_ack = 1'b1;
            end
        end else if (cmd_valid) begin
            en_d  = 1'b1;
            trg_d = cmd_trigger;
            d1_d  = cmd_d1;
            d2_d  = cmd_d2;
        end
    end

    // Handshake registers; reset drops lcd_en on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            trg_q <= TRG_IDLE;
            d1_q  <= 16'd0;
            d2_q  <= 16'd0;
        end else begin
            en_q  <= en_d;
            trg_q <= trg_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
        end
    end

    assign lcd_en      = en_q;
    assign lcd_trigger = trg_q;
    assign lcd_data1   = d1_q;
    assign lcd_data2   = d2_q;

endmodule : tft43_cmd_issuer
`default_nettype wire

// File: rtl/tft43_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tft43_fill_ctrl
// Description : Sequencer above the TFT43 command engine. Runs LCD power-up
//               (reset, init, display on), then serves rectangle fills as
//               CASET, RASET, GRAM start and one data write per pixel.
//               Out-of-range or unordered rectangles are rejected in idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tft43_fill_ctrl
    import tft43_pkg::*;
#(
    parameter int H_RES     = 800,
    parameter int V_RES     = 480,
    parameter int AUTO_INIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x0,
    input  logic [15:0] req_y0,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    input  rgb565_t     req_color,
    output logic        init_done,
    output logic        busy,
    output logic        fill_done,
    output logic        req_err,
    output logic        lcd_en,
    output logic [3:0]  lcd_trigger,
    output logic [15:0] lcd_data1,
    output logic [15:0] lcd_data2,
    input  logic        lcd_done
);

    localparam logic [15:0] X_LIM = 16'(H_RES);
    localparam logic [15:0] Y_LIM = 16'(V_RES);

    state_t      state_q, state_d;
    logic [15:0] x0_q, x0_d;
    logic [15:0] y0_q, y0_d;
    logic [15:0] x1_q, x1_d;
    logic [15:0] y1_q, y1_d;
    rgb565_t     color_q, color_d;
    logic [15:0] cx_q, cx_d;
    logic [15:0] cy_q, cy_d;
    logic        init_done_q, init_done_d;

    logic        cmd_valid;
    logic [3:0]  cmd_trigger;
    logic [15:0] cmd_d1;
    logic [15:0] cmd_d2;
    logic        cmd_ack;
    logic        req_legal;

    assign req_legal = rect_legal(req_x0, req_y0, req_x1, req_y1, X_LIM, Y_LIM);

    // Sequencing, command selection and the column/row walk
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        init_done_d = init_done_q;
        cmd_valid   = 1'b0;
        cmd_trigger = TRG_IDLE;
        cmd_d1      = 16'd0;
        cmd_d2      = 16'd0;
        req_ready   = 1'b0;
        req_err     = 1'b0;
        fill_done   = 1'b0;
        busy        = 1'b1;

        case (state_q)
            S_PWR_WAIT: begin
                busy = 1'b0;
                if ((AUTO_INIT != 0) || init_start) begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_RST;
                if (cmd_ack) state_d = S_INIT;
            end
            S_INIT: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_INIT;
                if (cmd_ack) state_d = S_DISP;
            end
            S_DISP: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_DISP;
                cmd_d1      = 16'd1;
                if (cmd_ack) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_legal) begin
                        // Rejected in place: nothing reaches the engine
                        req_err = 1'b1;
                    end else begin
                        x0_d    = req_x0;
                        y0_d    = req_y0;
                        x1_d    = req_x1;
                        y1_d    = req_y1;
                        color_d = req_color;
                        cx_d    = req_x0;
                        cy_d    = req_y0;
                        state_d = S_CASET;
                    end
                end
            end
            S_CASET: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_CASET;
                cmd_d1      = x0_q;
                cmd_d2      = x1_q;
                if (cmd_ack) state_d = S_RASET;
            end
            S_RASET: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_RASET;
                cmd_d1      = y0_q;
                cmd_d2      = y1_q;
                if (cmd_ack) state_d = S_GRAM;
            end
            S_GRAM: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_GRAM;
                cmd_d1      = 16'd1;
                if (cmd_ack) state_d = S_PIX;
            end
            S_PIX: begin
                cmd_valid   = 1'b1;
                cmd_trigger = TRG_DATA;
                cmd_d1      = color_q;
                if (cmd_ack) begin
                    if (cx_q == x1_q) begin
                        if (cy_q == y1_q) begin
                            state_d = S_FIN;
                        end else begin
                            cx_d = x0_q;
                            cy_d = cy_q + 16'd1;
                        end
                    end else begin
                        cx_d = cx_q + 16'd1;
                    end
                end
            end
            S_FIN: begin
                fill_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_PWR_WAIT;
            end
        endcase
    end

    // Sequencer state, captured rectangle and walk counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_PWR_WAIT;
            x0_q        <= 16'd0;
            y0_q        <= 16'd0;
            x1_q        <= 16'd0;
            y1_q        <= 16'd0;
            color_q     <= '0;
            cx_q        <= 16'd0;
            cy_q        <= 16'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    tft43_cmd_issuer u_issuer (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_trigger (cmd_trigger),
        .cmd_d1      (cmd_d1),
        .cmd_d2      (cmd_d2),
        .cmd_ack     (cmd_ack),
        .lcd_en      (lcd_en),
        .lcd_trigger (lcd_trigger),
        .lcd_data1   (lcd_data1),
        .lcd_data2   (lcd_data2),
        .lcd_done    (lcd_done)
    );

endmodule : tft43_fill_ctrl
`default_nettype wire

// File: tb/tb_tft43_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tft43_fill_ctrl
// Description : Directed bench for tft43_fill_ctrl with a mock command engine
//               that answers lcd_done five cycles after lcd_en rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tft43_fill_ctrl;

    typedef struct {
        logic [3:0]  t;
        logic [15:0] d1;
        logic [15:0] d2;
        int          gap;
        int          cyc;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // DUT A: auto power-up
    logic        rst_n = 1'b0, init_start = 1'b0, req_valid = 1'b0;
    logic [15:0] req_x0 = 0, req_y0 = 0, req_x1 = 0, req_y1 = 0, req_color = 0;
    logic        req_ready, init_done, busy, fill_done, req_err, lcd_en;
    logic [3:0]  lcd_trigger;
    logic [15:0] lcd_data1, lcd_data2;
    logic        lcd_done = 1'b0;

    // DUT B: waits for init_start
    logic        rst_n_b = 1'b0, init_start_b = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_b, init_done_b, busy_b, fill_done_b, req_err_b, lcd_en_b;
    logic [3:0]  lcd_trigger_b;
    logic [15:0] lcd_data1_b, lcd_data2_b;
    logic        lcd_done_b = 1'b0;

    tft43_fill_ctrl #(.H_RES(800), .V_RES(480), .AUTO_INIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_color(req_color), .init_done(init_done), .busy(busy),
        .fill_done(fill_done), .req_err(req_err), .lcd_en(lcd_en),
        .lcd_trigger(lcd_trigger), .lcd_data1(lcd_data1),
        .lcd_data2(lcd_data2), .lcd_done(lcd_done)
    );

    tft43_fill_ctrl #(.H_RES(800), .V_RES(480), .AUTO_INIT(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .init_start(init_start_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_color(req_color), .init_done(init_done_b), .busy(busy_b),
        .fill_done(fill_done_b), .req_err(req_err_b), .lcd_en(lcd_en_b),
        .lcd_trigger(lcd_trigger_b), .lcd_data1(lcd_data1_b),
        .lcd_data2(lcd_data2_b), .lcd_done(lcd_done_b)
    );

    // Mock engine A: logs each completed command with the low time before it
    rec_t        q_a[$];
    int          cnt_a = 0, low_a = 0, gap_a = 0, stab_a = 0, fd_a = 0;
    logic        en_seen_a = 1'b0;
    logic [35:0] snap_a = '0;
    always @(negedge clk) begin
        if (fill_done) fd_a++;
        if (lcd_en) begin
            en_seen_a = 1'b1;
            cnt_a++;
            if (cnt_a == 1) begin
                gap_a  = low_a;
                low_a  = 0;
                snap_a = {lcd_trigger, lcd_data1, lcd_data2};
            end else if ({lcd_trigger, lcd_data1, lcd_data2} !== snap_a) begin
                stab_a++;
            end
            lcd_done = (cnt_a == 5);
            if (cnt_a == 5)
                q_a.push_back('{t: lcd_trigger, d1: lcd_data1, d2: lcd_data2, gap: gap_a, cyc: cyc});
        end else begin
            cnt_a    = 0;
            low_a++;
            lcd_done = 1'b0;
        end
    end

    // Mock engine B
    rec_t        q_b[$];
    int          cnt_b = 0, low_b = 0, gap_b = 0, stab_b = 0;
    logic        en_seen_b = 1'b0;
    logic [35:0] snap_b = '0;
    always @(negedge clk) begin
        if (lcd_en_b) begin
            en_seen_b = 1'b1;
            cnt_b++;
            if (cnt_b == 1) begin
                gap_b  = low_b;
                low_b  = 0;
                snap_b = {lcd_trigger_b, lcd_data1_b, lcd_data2_b};
            end else if ({lcd_trigger_b, lcd_data1_b, lcd_data2_b} !== snap_b) begin
                stab_b++;
            end
            lcd_done_b = (cnt_b == 5);
            if (cnt_b == 5)
                q_b.push_back('{t: lcd_trigger_b, d1: lcd_data1_b, d2: lcd_data2_b, gap: gap_b, cyc: cyc});
        end else begin
            cnt_b      = 0;
            low_b++;
            lcd_done_b = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; report err/ready on that cycle
    // and ready on the following one
    task automatic send_req(input logic [15:0] x0, input logic [15:0] y0,
                            input logic [15:0] x1, input logic [15:0] y1,
                            input logic [15:0] col,
                            output logic err, output logic rdy, output logic rdy_next);
        @(negedge clk);
        req_x0 = x0; req_y0 = y0; req_x1 = x1; req_y1 = y1; req_color = col;
        req_valid = 1'b1;
        #1;
        err = req_err;
        rdy = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rdy_next = req_ready;
    endtask

    task automatic wait_fill(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (fill_done) begin ok = 1'b1; break; end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic err, rdy, rdy_n, ok;
        int   nb, t_now, fd0;
        logic [15:0] rx0 [3];
        logic [15:0] ry0 [3];
        logic [15:0] rx1 [3];
        logic [15:0] ry1 [3];

        // ---- Scenario 1: reset state and auto power-up ----
        repeat (3) @(negedge clk);
        chk("rst_lcd_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_trigger", {28'd0, lcd_trigger}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        ok = 1'b0; nb = 0; t_now = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1'b1; t_now = cyc; break; end
            if (!busy) nb++;
        end
        chk("pwrup_reached", {31'd0, ok}, 32'd1);
        chk("pwrup_busy_drops", nb, 0);
        chk("pwrup_ncmd", q_a.size(), 3);
        chk("pwrup_trg0", {28'd0, q_a[0].t}, 32'd1);
        chk("pwrup_trg1", {28'd0, q_a[1].t}, 32'd2);
        chk("pwrup_trg2", {28'd0, q_a[2].t}, 32'd6);
        chk("pwrup_disp_d1", {16'd0, q_a[2].d1}, 32'd1);
        chk("pwrup_gap1", q_a[1].gap, 1);
        chk("pwrup_gap2", q_a[2].gap, 1);
        chk("init_done_lat", t_now - q_a[2].cyc, 1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // ---- Scenario 2: 3x2 fill ----
        q_a.delete();
        fd0 = fd_a;
        send_req(16'd10, 16'd20, 16'd12, 16'd21, 16'hF800, err, rdy, rdy_n);
        chk("fill_accept_ready", {31'd0, rdy}, 32'd1);
        chk("fill_accept_err", {31'd0, err}, 32'd0);
        chk("fill_ready_drop", {31'd0, rdy_n}, 32'd0);
        chk("fill_busy", {31'd0, busy}, 32'd1);
        req_x0 = 16'd0; req_x1 = 16'd0; req_color = 16'h1234;
        wait_fill("fill_done_seen");
        repeat (3) @(negedge clk);
        chk("fill_done_count", fd_a - fd0, 1);
        chk("fill_ready_back", {31'd0, req_ready}, 32'd1);
        chk("fill_ncmd", q_a.size(), 9);
        chk("caset", {q_a[0].t, q_a[0].d1, q_a[0].d2[11:0]}, {4'd3, 16'd10, 12'd12});
        chk("raset", {q_a[1].t, q_a[1].d1, q_a[1].d2[11:0]}, {4'd4, 16'd20, 12'd21});
        chk("gram", {12'd0, q_a[2].t, q_a[2].d1}, {12'd0, 4'd5, 16'd1});
        for (int i = 3; i < 9; i++)
            chk("pix_write", {12'd0, q_a[i].t, q_a[i].d1}, {12'd0, 4'd7, 16'hF800});
        for (int i = 1; i < 9; i++)
            chk("fill_gap", q_a[i].gap, 1);

        // ---- Scenario 3: rejects ----
        rx0[0] = 5; ry0[0] = 0;   rx1[0] = 4;   ry1[0] = 0;
        rx0[1] = 0; ry0[1] = 0;   rx1[1] = 800; ry1[1] = 0;
        rx0[2] = 0; ry0[2] = 0;   rx1[2] = 0;   ry1[2] = 480;
        for (int r = 0; r < 3; r++) begin
            q_a.delete();
            en_seen_a = 1'b0;
            send_req(rx0[r], ry0[r], rx1[r], ry1[r], 16'h07E0, err, rdy, rdy_n);
            chk("rej_err_pulse", {31'd0, err}, 32'd1);
            #1;
            chk("rej_err_single", {31'd0, req_err}, 32'd0);
            chk("rej_stays_idle", {30'd0, rdy_n, busy}, {30'd0, 1'b1, 1'b0});
            repeat (10) @(negedge clk);
            chk("rej_no_lcd", {31'd0, en_seen_a}, 32'd0);
        end

        // ---- Scenario 4: single pixel at the far corner ----
        q_a.delete();
        fd0 = fd_a;
        send_req(16'd799, 16'd479, 16'd799, 16'd479, 16'h07E0, err, rdy, rdy_n);
        chk("corner_err", {31'd0, err}, 32'd0);
        wait_fill("corner_done_seen");
        repeat (3) @(negedge clk);
        chk("corner_done_count", fd_a - fd0, 1);
        chk("corner_ncmd", q_a.size(), 4);
        chk("corner_caset", {q_a[0].t, q_a[0].d1, q_a[0].d2[11:0]}, {4'd3, 16'd799, 12'd799});
        chk("corner_raset", {q_a[1].t, q_a[1].d1, q_a[1].d2[11:0]}, {4'd4, 16'd479, 12'd479});
        chk("corner_pix", {12'd0, q_a[3].t, q_a[3].d1}, {12'd0, 4'd7, 16'h07E0});

        // ---- Scenario 5: reset during the third pixel write ----
        q_a.delete();
        send_req(16'd0, 16'd0, 16'd3, 16'd0, 16'h001F, err, rdy, rdy_n);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q_a.size() >= 5) begin ok = 1'b1; break; end
        end
        for (int i = 0; i < 20 && lcd_en; i++) @(negedge clk);
        for (int i = 0; i < 20 && !lcd_en; i++) @(negedge clk);
        chk("midrst_reached", {30'd0, ok, lcd_en}, {30'd0, 1'b1, 1'b1});
        chk("midrst_trg", {28'd0, lcd_trigger}, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_en_low", {31'd0, lcd_en}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        q_a.delete();
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1'b1; break; end
        end
        repeat (20) @(negedge clk);
        chk("repwr_reached", {31'd0, ok}, 32'd1);
        chk("repwr_ncmd", q_a.size(), 3);
        chk("repwr_trgs", {20'd0, q_a[0].t, q_a[1].t, q_a[2].t}, {20'd0, 4'd1, 4'd2, 4'd6});

        // ---- Scenario 6: manual power-up ----
        @(negedge clk);
        rst_n_b = 1'b1;
        en_seen_b = 1'b0;
        repeat (100) @(negedge clk);
        chk("manual_quiet", {30'd0, en_seen_b, init_done_b}, 32'd0);
        chk("manual_quiet_busy", {31'd0, busy_b}, 32'd0);
        init_start_b = 1'b1;
        @(negedge clk);
        init_start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done_b) begin ok = 1'b1; break; end
        end
        chk("manual_reached", {31'd0, ok}, 32'd1);
        chk("manual_ncmd", q_b.size(), 3);
        chk("manual_trgs", {20'd0, q_b[0].t, q_b[1].t, q_b[2].t}, {20'd0, 4'd1, 4'd2, 4'd6});
        chk("manual_disp_d1", {16'd0, q_b[2].d1}, 32'd1);
        chk("manual_gaps", {q_b[1].gap[15:0], q_b[2].gap[15:0]}, {16'd1, 16'd1});
        init_start_b = 1'b1;
        @(negedge clk);
        init_start_b = 1'b0;
        repeat (40) @(negedge clk);
        chk("manual_restart_ignored", q_b.size(), 3);
        chk("manual_idle_busy", {31'd0, busy_b}, 32'd0);

        chk("stable_a", stab_a, 0);
        chk("stable_b", stab_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tft43_fill_ctrl
`default_nettype wire

// File: doc/tft43_fill_ctrl.md
Name: tft43_fill_ctrl

Overview:
Sequencer that sits above the TFT43 command engine (the 4-bit trigger / data1 / data2 / done interface) and owns its command port.
- After reset it runs LCD power-up: hardware reset, then register init, then display ON.
- It then serves rectangle-fill requests from the pixel/graphics side. Each fill issues CASET, RASET and GRAM-write start, followed by one data-write command per pixel.
- Illegal rectangles are validated and rejected, so the panel engine never receives out-of-range addresses.

Parameters:
H_RES, 800, panel columns; legal x range is 0..H_RES-1.
V_RES, 480, panel rows; legal y range is 0..V_RES-1.
AUTO_INIT, 1, 1 = start power-up automatically after reset; 0 = wait for init_start.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
init_start  in  1  single-cycle pulse; starts power-up when AUTO_INIT=0; ignored otherwise and ignored once init_done=1
req_valid  in  1  fill request valid
req_ready  out  1  request accepted on cycle where req_valid & req_ready
req_x0  in  16  start column
req_y0  in  16  start row
req_x1  in  16  end column, inclusive
req_y1  in  16  end row, inclusive
req_color  in  16  RGB565 fill colour
init_done  out  1  high from the end of power-up until reset
busy  out  1  high whenever a command sequence is in progress
fill_done  out  1  single-cycle pulse after the last pixel's done
req_err  out  1  single-cycle pulse on the acceptance cycle of a rejected request
lcd_en  out  1  enable to the command engine
lcd_trigger  out  4  command code: 1 reset, 2 init, 3 CASET, 4 RASET, 5 GRAM, 6 display, 7 data
lcd_data1  out  16  command operand 1
lcd_data2  out  16  command operand 2
lcd_done  in  1  single-cycle done pulse from the command engine

Behaviour:
- Reset values (rst_n=0 at a clk edge): all outputs 0, FSM in S_PWR_WAIT, counters 0. Reset mid-command drops lcd_en the same edge; no pending state survives.
- Command handshake, per command:
  - Drive lcd_trigger, lcd_data1, lcd_data2 and lcd_en=1, holding them stable until lcd_done=1 is sampled.
  - On that edge, lcd_en goes to 0 for exactly one cycle (GAP). This re-arms the engine's step counter.
  - The next command is then presented. Trigger and data only change while lcd_en=0 or on the done edge.
- Command cost is engine latency + 1 cycle. lcd_done seen while lcd_en=0 is ignored.
- FSM states:
  - S_PWR_WAIT: go to S_RST when AUTO_INIT=1, or when init_start=1.
  - S_RST: trigger 1.
  - S_INIT: trigger 2.
  - S_DISP: trigger 6, data1=1.
  - S_IDLE: init_done=1, req_ready=1, busy=0.
  - S_CASET: trigger 3, data1=x0, data2=x1.
  - S_RASET: trigger 4, data1=y0, data2=y1.
  - S_GRAM: trigger 5, data1=1.
  - S_PIX: trigger 7, data1=color, repeated per pixel.
  - S_FIN: fill_done pulse, then S_IDLE.
- busy=1 in every state except S_PWR_WAIT and S_IDLE.
- Request acceptance:
  - x0,y0,x1,y1,color are registered on the accept cycle. req_ready drops the next cycle.
  - Rejection condition: x0>x1, y0>y1, x1>=H_RES or y1>=V_RES. On rejection, req_err pulses, the FSM stays in S_IDLE, and no LCD command is issued.
  - A legal request moves to S_CASET on the next cycle.
- Pixel loop:
  - Column counter cx runs x0..x1; row counter cy runs y0..y1.
  - After each lcd_done in S_PIX: if cx==x1, cx<=x0 and cy increments; otherwise cx increments.
  - The loop exits when the done arrives with cx==x1 and cy==y1.
  - Counters are 16 bit; no multiplication. Total writes = (x1-x0+1)*(y1-y0+1); maximum 384000 (800 x 480).
- Single-pixel rectangle (x0==x1, y0==y1): exactly one data write.
- req_valid while busy: held off, since req_ready=0. Inputs are sampled only on accept, so request changes mid-fill have no effect.

Decomposition:
- Package tft43_pkg holds:
  - trigger-code constants: TRG_IDLE=0, TRG_RST=1, TRG_INIT=2, TRG_CASET=3, TRG_RASET=4, TRG_GRAM=5, TRG_DISP=6, TRG_DATA=7;
  - the FSM state enum;
  - the RGB565 colour typedef.
- Sub-module tft43_cmd_issuer owns the en/done/GAP handshake. Its interface is cmd_valid, cmd_trigger, cmd_d1, cmd_d2, cmd_ack, plus the lcd_* pins.
- The top FSM contains only sequencing and the counters.

Test Plan:
Bench uses a mock engine that pulses lcd_done 5 cycles after lcd_en rises and checks that lcd_en falls for exactly one cycle between commands.
1. Reset, AUTO_INIT=1 -> triggers 1, 2, 6 (data1=1) in order; init_done rises the cycle after the third done; busy=1 throughout.
2. Fill (10,20)-(12,21), colour 0xF800 -> triggers 3 (10,12), 4 (20,21), 5 (1), then six trigger-7 writes of 0xF800; single fill_done; req_ready back high.
3. Rejects: (5,0)-(4,0), and (0,0)-(800,0) with H_RES=800 -> req_err pulse each time, lcd_en stays 0, state stays IDLE.
4. Single pixel (799,479)-(799,479) -> exactly one data write; fill_done pulses.
5. rst_n low during the 3rd pixel write -> lcd_en=0 next edge, init_done=0; full power-up re-runs; no further data writes.
6. AUTO_INIT=0 -> no LCD activity for 100 cycles; init_start pulse -> power-up sequence as in scenario 1.
